encoder_negedge: RTL and testbench



---
 rtl/counter_pkg.sv | 7 +
 rtl/encoder_negedge.sv | 85 ++++++++
 tb/tb_encoder_negedge.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared state type and width helper for the temporal counter library
package counter_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} encoder_state_t;
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction
endpackage

// File: rtl/encoder_negedge.sv
// encoder_negedge: temporal encoder, value carried by the falling edge of a high pulse of MAX_VALUE-value cycles
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid/in_ready     : handshake, transfer when both high at a rising edge
//   in_value              : value to encode, values above MAX_VALUE clamp to MAX_VALUE
//   cancel                : synchronous abort, also blocks a transfer in IDLE
//   outgoing_line, done   : registered coded line and one-cycle frame-complete pulse
//   busy                  : frame or guard interval in progress
module encoder_negedge
  import counter_pkg::*;
#(
  parameter int MAX_VALUE   = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int W  = cnt_width(MAX_VALUE),
  localparam int HW = cnt_width(HOLD_CYCLES - 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_value,
  input  logic         cancel,
  output logic         outgoing_line,
  output logic         done,
  output logic         busy
);
  localparam logic [W-1:0]  MAXV  = W'(MAX_VALUE);
  localparam logic [HW-1:0] HOLDV = HW'(HOLD_CYCLES - 1);
  encoder_state_t state_q, state_d;
  logic line_q, line_d, done_q, done_d;
  logic [W-1:0] pulse_q, pulse_d, n;
  logic [HW-1:0] hold_q, hold_d;
  assign n = (in_value > MAXV) ? '0 : MAXV - in_value;
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign outgoing_line = line_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    done_d  = 1'b0;
    pulse_d = pulse_q;
    hold_d  = hold_q;
    if (cancel) begin
      state_d = IDLE;
      line_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_d = (n != '0) ? ACTIVE : HOLD;
          line_d  = n != '0;
          done_d  = n == '0;
          pulse_d = n;
          hold_d  = HOLDV;
        end
        ACTIVE: if (pulse_q == W'(1)) begin
          state_d = HOLD;
          line_d  = 1'b0;
          done_d  = 1'b1;
          hold_d  = HOLDV;
        end else pulse_d = pulse_q - W'(1);
        HOLD: if (hold_q == '0) state_d = IDLE;
              else hold_d = hold_q - HW'(1);
        default: begin
          state_d = IDLE;
          line_d  = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_encoder_negedge.sv
// tb_encoder_negedge: scoreboard bench for encoder_negedge (HOLD 2 main instance, HOLD 1 corner instance)
module tb_encoder_negedge;
  localparam int MAX = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, cancel = 1'b0, in_ready, line, done, busy;
  logic [3:0] in_value = '0;
  logic in_valid_1 = 1'b0, in_ready_1, line_1, done_1, busy_1;
  logic [3:0] in_value_1 = '0;
  logic cancel_1 = 1'b0;
  int n_checks = 0, n_fail = 0, cyc = 0, run = 0;
  typedef struct {int value; int start;} frame_t;
  frame_t sb[$];

  encoder_negedge #(.MAX_VALUE(MAX), .HOLD_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .cancel(cancel), .outgoing_line(line), .done(done), .busy(busy));
  encoder_negedge #(.MAX_VALUE(MAX), .HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_value(in_value_1), .cancel(cancel_1), .outgoing_line(line_1), .done(done_1), .busy(busy_1));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !in_ready; i++) step();
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input int v);
    wait_ready();
    in_valid = 1'b1;
    in_value = 4'(v);
    step();
    in_valid = 1'b0;
    wait_ready();
  endtask

  always @(negedge clock) begin
    frame_t f;
    cyc++;
    if (reset) begin
      sb.delete();
      run = 0;
    end else begin
      if (line) run++;
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", done, 0);
        else begin
          f = sb.pop_front();
          check("recovered_value", MAX - run, clamp(f.value));
          check("fall_latency", cyc - f.start, MAX - clamp(f.value) + 1);
          check("line_low_at_done", line, 0);
        end
        run = 0;
      end
      if (cancel && busy) begin
        if (sb.size() > 0) void'(sb.pop_front());
        run = 0;
      end
      if (in_valid && in_ready && !cancel) sb.push_back('{int'(in_value), cyc});
    end
  end

  logic exp_line [6] = '{1, 1, 1, 0, 0, 0};
  logic exp_done [6] = '{0, 0, 0, 1, 0, 0};
  logic exp_rdy  [6] = '{0, 0, 0, 0, 0, 1};
  logic exp_l1   [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic exp_d1   [8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    repeat (2) step();
    check("rst_line", line, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    in_valid = 1'b1;
    in_value = 4'd5;
    for (int k = 0; k < 6; k++) begin
      step();
      in_valid = 1'b0;
      in_value = 4'd0;
      check($sformatf("v5_line_c%0d", k + 1), line, exp_line[k]);
      check($sformatf("v5_done_c%0d", k + 1), done, exp_done[k]);
      check($sformatf("v5_ready_c%0d", k + 1), in_ready, exp_rdy[k]);
    end
    send(0);
    send(8);
    send(12);
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 15)));
    in_valid = 1'b1;
    in_value = 4'd3;
    step();
    in_value = 4'd6;
    for (int k = 2; k <= 8; k++) begin
      step();
      check($sformatf("b2b_ready_c%0d", k), in_ready, k == 8);
    end
    step();
    in_valid = 1'b0;
    check("b2b_second_line", line, 1);
    wait_ready();
    in_valid = 1'b1;
    in_value = 4'd0;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("cancel_line_before", line, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_line", line, 0);
    check("cancel_ready", in_ready, 1);
    check("cancel_done", done, 0);
    repeat (10) step();
    in_valid = 1'b1;
    in_value = 4'd1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("rst_mid_line_before", line, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_line", line, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    step();
    reset = 1'b0;
    send(7);
    in_valid_1 = 1'b1;
    in_value_1 = 4'd6;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("h1_line_c%0d", k + 1), line_1, exp_l1[k]);
      check($sformatf("h1_done_c%0d", k + 1), done_1, exp_d1[k]);
    end
    in_valid_1 = 1'b0;
    repeat (12) step();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
